// File: rtl/frame_buffer_pingpong.sv
// Double-buffered camera frame store: the camera fills one bank while the
// reader scans the other, and the banks swap only on complete, unlocked frames.
module frame_buffer_pingpong #(
    parameter int DATA_W = 8,
    parameter int H_RES  = 176,
    parameter int V_RES  = 120,
    parameter int DEPTH  = H_RES * V_RES,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_sof,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_lock,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_ready,
    output logic              wr_bank,
    output logic              short_frame,
    output logic [7:0]        drop_cnt
);

    localparam int MEM_AW = $clog2(2 * DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [MEM_AW-1:0] BANK_OFS = MEM_AW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_bank;
    logic              swap_pending;

    logic [DATA_W-1:0] mem [2*DEPTH];

    logic              complete;
    logic              swap_now;
    logic              drop;
    logic              bank_eff;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_loc;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;

    // A pending swap that executes this edge redirects a same-cycle sof pixel
    // into the newly assigned write bank.
    always_comb begin
        complete = (state == WRITE) && !wr_sof && wr_valid && (wr_addr == LAST);
        swap_now = !rd_lock && (complete || swap_pending);
        drop     = rd_lock && swap_pending && wr_sof;
        bank_eff = wr_bank ^ (swap_pending && !rd_lock);
        wr_en    = wr_valid && (wr_sof || (state == WRITE));
        wr_loc   = wr_sof ? '0 : wr_addr;
        wr_idx   = MEM_AW'(wr_loc) + (bank_eff ? BANK_OFS : '0);
        rd_idx   = MEM_AW'(rd_addr) + (rd_bank ? BANK_OFS : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_addr      <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b1;
            swap_pending <= 1'b0;
            frame_ready  <= 1'b0;
            short_frame  <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            frame_ready <= swap_now;
            short_frame <= wr_sof && (state == WRITE);

            if (swap_now) begin
                wr_bank      <= ~wr_bank;
                rd_bank      <= ~rd_bank;
                swap_pending <= 1'b0;
            end else if (complete) begin
                swap_pending <= 1'b1;
            end else if (drop) begin
                swap_pending <= 1'b0;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end

            if (wr_sof) begin
                state   <= WRITE;
                wr_addr <= wr_valid ? ADDR_W'(1) : '0;
            end else begin
                unique case (state)
                    WRITE: begin
                        if (wr_valid) begin
                            wr_addr <= complete ? '0 : wr_addr + ADDR_W'(1);
                            if (complete)
                                state <= DONE;
                        end
                    end
                    IDLE, DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    // Out-of-range reads answer zero without touching the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= ({1'b0, rd_addr} >= DEPTH_P) ? '0 : mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Bench for frame_buffer_pingpong: directed plan plus random traffic,
// checked against a frame-level model of what the reader may see.
module tb_frame_buffer_pingpong;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_sof, wr_valid, rd_en, rd_lock;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid, frame_ready, wr_bank, short_frame;
    logic [7:0]    drop_cnt;

    frame_buffer_pingpong #(
        .DATA_W(DW), .H_RES(4), .V_RES(2), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_lock(rd_lock),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_ready(frame_ready), .wr_bank(wr_bank),
        .short_frame(short_frame), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Frame-level model: what is readable, what is being assembled.
    int         cnt;
    bit         fin, pend, known, rd_known;
    bit         m_bank;
    int         drops;
    logic [7:0] rdbl [N];
    logic [7:0] done_f [N];
    logic [7:0] wbuf [N];
    logic [7:0] e_rd;
    bit         e_rv, e_fr, e_sf;

    task automatic model_reset();
        cnt = -1; fin = 0; pend = 0; known = 0; rd_known = 1;
        m_bank = 0; drops = 0; e_rd = 0; e_rv = 0; e_fr = 0; e_sf = 0;
    endtask

    task automatic do_swap();
        rdbl = done_f; known = 1; m_bank = ~m_bank; pend = 0; e_fr = 1;
    endtask

    task automatic model_edge();
        e_fr = 0; e_sf = 0; e_rv = rd_en;
        if (rd_en) begin
            if (rd_addr >= AW'(N)) begin e_rd = 0; rd_known = 1; end
            else begin e_rd = rdbl[rd_addr]; rd_known = known; end
        end
        if (pend && !rd_lock) do_swap();
        if (wr_sof) begin
            if (cnt >= 0 && !fin) e_sf = 1;
            if (pend && rd_lock) begin
                pend = 0;
                if (drops < 255) drops++;
            end
            cnt = 0; fin = 0;
            if (wr_valid) begin wbuf[0] = wr_data; cnt = 1; end
        end else if (cnt >= 0 && !fin && wr_valid) begin
            wbuf[cnt] = wr_data;
            cnt++;
            if (cnt == N) begin
                fin = 1; done_f = wbuf;
                if (!rd_lock) do_swap();
                else pend = 1;
            end
        end
    endtask

    task automatic check_outs();
        chk("rd_valid", 32'(rd_valid), 32'(e_rv));
        chk("frame_ready", 32'(frame_ready), 32'(e_fr));
        chk("short_frame", 32'(short_frame), 32'(e_sf));
        chk("wr_bank", 32'(wr_bank), 32'(m_bank));
        chk("drop_cnt", 32'(drop_cnt), 32'(drops));
        if (rd_known) chk("rd_data", 32'(rd_data), 32'(e_rd));
    endtask

    task automatic step(input bit sof, input bit vld, input logic [7:0] d,
                        input bit ren, input logic [AW-1:0] a, input bit lck);
        wr_sof = sof; wr_valid = vld; wr_data = d;
        rd_en = ren; rd_addr = a; rd_lock = lck;
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic frame(input logic [7:0] base, input int n, input bit lck);
        step(1, 0, 8'h00, 0, '0, lck);
        for (int i = 0; i < n; i++)
            step(0, 1, base + 8'(i), 0, '0, lck);
    endtask

    task automatic read_all(input bit lck);
        for (int a = 0; a < N; a++)
            step(0, 0, 8'h00, 1, AW'(a), lck);
        step(0, 0, 8'h00, 0, '0, lck);
    endtask

    initial begin
        rst_n = 0; wr_sof = 0; wr_valid = 0; wr_data = 0;
        rd_en = 0; rd_addr = 0; rd_lock = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outs();
        rst_n = 1;

        frame(8'h10, 8, 0);
        read_all(0);

        frame(8'h20, 8, 1);
        read_all(1);
        step(0, 0, 8'h00, 0, '0, 0);
        read_all(0);

        frame(8'h30, 8, 1);
        frame(8'h40, 8, 1);
        read_all(1);
        step(0, 0, 8'h00, 0, '0, 0);
        read_all(0);

        frame(8'h00, 5, 0);
        frame(8'h50, 8, 0);
        read_all(0);

        frame(8'h60, 8, 0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 8'hE0 + 8'(i), 0, '0, 0);
        read_all(0);
        step(0, 0, 8'h00, 1, AW'(9), 0);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
                 8'($urandom), $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 9)), $urandom_range(0, 3) == 0);

        frame(8'h70, 8, 1);
        frame(8'h00, 3, 1);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        #2;
        rst_n = 1;

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
                 8'($urandom), $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 9)), $urandom_range(0, 4) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_buffer_pingpong.md
Name: frame_buffer_pingpong

Overview:
Parametrised, single-clock, double-buffered (ping-pong) frame store for the camera pixel path.
- The camera side streams pixels in with a start-of-frame strobe; write addresses are generated internally.
- The display/processing side reads by address from the opposite bank.
- Banks swap only on a complete frame, and only when the reader is not mid-scan, so the reader never sees a torn frame.

Parameters:
DATA_W, 8, pixel width in bits
H_RES, 176, pixels per line
V_RES, 120, lines per frame
DEPTH, H_RES*V_RES, pixels per bank (derived; do not override)
ADDR_W, 15, address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
clk  input  1  single clock for both sides
rst_n  input  1  asynchronous active-low reset
wr_sof  input  1  start-of-frame pulse from camera side
wr_valid  input  1  wr_data is a valid pixel this cycle
wr_data  input  DATA_W  pixel in
rd_en  input  1  read request
rd_addr  input  ADDR_W  read pixel address within the read bank
rd_lock  input  1  high while the reader scans a frame; blocks bank swap
rd_data  output  DATA_W  read pixel
rd_valid  output  1  rd_data valid
frame_ready  output  1  one-cycle pulse when a new frame becomes readable
wr_bank  output  1  bank currently being written
short_frame  output  1  one-cycle pulse: wr_sof arrived before DEPTH pixels were written
drop_cnt  output  8  count of completed frames discarded without display, saturating at 255

Behaviour:
- Reset (async, rst_n=0): write FSM=IDLE; wr_addr=0; wr_bank=0; read bank=1; swap_pending=0; rd_data=0; rd_valid=0; frame_ready=0; short_frame=0; drop_cnt=0. Memory contents are not reset.
- Storage: 2*DEPTH words. Physical address = bank*DEPTH + local address. Write port and read port are independent in the same cycle.
- Write FSM:
  - IDLE: wr_valid ignored. wr_sof -> WRITE with wr_addr=0. If wr_valid is also high that cycle, the pixel is written at address 0 and wr_addr becomes 1.
  - WRITE: each wr_valid writes mem[wr_bank][wr_addr] and increments wr_addr. The write at wr_addr=DEPTH-1 completes the frame -> DONE next cycle.
  - WRITE + wr_sof before completion: short_frame pulses; wr_addr restarts at 0 (same-cycle pixel handling as in IDLE); no swap; the bank is reused.
  - DONE: wr_valid ignored (overflow pixels dropped). wr_sof -> WRITE in the same bank if not yet swapped, else in the new wr_bank.
- Swap on frame completion (the cycle of the DEPTH-1 write):
  - rd_lock=0: swap on the next edge. wr_bank toggles, read bank toggles, frame_ready pulses 1 cycle.
  - rd_lock=1: swap_pending=1. Swap executes on the first cycle rd_lock is sampled 0, with frame_ready pulsing then.
  - wr_sof while swap_pending=1: the pending frame is discarded. swap_pending clears, drop_cnt increments (saturating), and the writer overwrites the same bank.
  - If a swap and a wr_sof coincide, the swap takes effect first; the new frame goes into the newly assigned write bank.
- Read:
  - Latency 1. rd_en in cycle N -> rd_data and rd_valid=1 in cycle N+1.
  - rd_en=0 -> rd_valid=0 next cycle; rd_data holds its last value.
  - Bank is sampled with rd_addr in cycle N, so a swap in cycle N affects only reads issued from N+1.
  - rd_addr >= DEPTH: rd_valid=1, rd_data=0, no memory access.
- The reader never accesses wr_bank, so same-address read/write collisions are impossible by construction.

Test Plan (H_RES=4, V_RES=2, DEPTH=8):
1. Fill and read: reset; wr_sof + 8 wr_valid pixels 0x10..0x17, rd_lock=0 -> frame_ready pulses once, wr_bank=1. Read addrs 0..7 -> 0x10..0x17, each one cycle after rd_en.
2. Swap blocked: hold rd_lock=1 during second frame 0x20..0x27 -> no frame_ready; reads still return 0x10..0x17. Drop rd_lock -> frame_ready next cycle; reads return 0x20..0x27.
3. Drop: rd_lock=1; complete frame 0x30..; issue wr_sof -> drop_cnt=1, no frame_ready. Complete frame 0x40..; release rd_lock -> reads return 0x40..0x47.
4. Short frame: wr_sof, 5 pixels, wr_sof, 8 pixels 0x50..0x57 -> short_frame pulses once; one frame_ready; reads return 0x50..0x57.
5. Overflow/bounds: 8 pixels then 3 extra wr_valid without wr_sof -> extras ignored. Read at rd_addr=9 -> rd_data=0, rd_valid=1.
6. Async reset mid-frame: assert rst_n=0 after 3 pixels without a clock edge -> outputs reach reset values immediately; drop_cnt=0, wr_bank=0.
